// File: rtl/shift_register_pkg.sv
// rtl/shift_register_pkg.sv - shared width and word type for the shift register family
package shift_register_pkg;
    localparam int WIDTH = 8;
    typedef logic [WIDTH-1:0] sr_word_t;
endpackage

// File: rtl/shift_register_family_cells.sv
// rtl/shift_register_family_cells.sv - level-sensitive latch and latch-built master-slave flop
module d_latch (
    input  logic en,
    input  logic d,
    output logic q
);
    always_latch begin
        if (en) begin
            q <= d;
        end
    end
endmodule

module d_flip_flop (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic w_m_en;
    logic w_s_en;
    logic w_m_d;
    logic w_s_d;
    logic w_m_q;

    // Reset opens both latches and feeds them 0, so the clear is immediate.
    assign w_m_en = ~clk | rst;
    assign w_s_en = clk | rst;
    assign w_m_d  = d & ~rst;
    assign w_s_d  = w_m_q & ~rst;

    d_latch u_master (.en(w_m_en), .d(w_m_d), .q(w_m_q));
    d_latch u_slave  (.en(w_s_en), .d(w_s_d), .q(q));
endmodule

// File: rtl/shift_register_family_variants.sv
// rtl/shift_register_family_variants.sv - latch-pair, flop-chain and behavioural SIPO shift registers
module shift_register_d #(
    parameter int WIDTH = shift_register_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             so
);
    logic             w_m_en;
    logic             w_s_en;
    logic [WIDTH-1:0] w_m_d;
    logic [WIDTH-1:0] w_m_q;
    logic [WIDTH-1:0] w_s_d;

    assign w_m_en = ~clk | rst;
    assign w_s_en = clk | rst;
    assign w_m_d  = rst ? '0 : {po[WIDTH-2:0], si};
    assign w_s_d  = rst ? '0 : w_m_q;
    assign so     = po[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_latch u_master (.en(w_m_en), .d(w_m_d[i]), .q(w_m_q[i]));
        d_latch u_slave  (.en(w_s_en), .d(w_s_d[i]), .q(po[i]));
    end
endmodule

module shift_register_dff #(
    parameter int WIDTH = shift_register_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             so
);
    logic [WIDTH-1:0] w_d;

    assign w_d = {po[WIDTH-2:0], si};
    assign so  = po[WIDTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ff
        d_flip_flop u_ff (.clk(clk), .rst(rst), .d(w_d[i]), .q(po[i]));
    end
endmodule

module shift_register_always #(
    parameter int WIDTH = shift_register_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] pi,
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] po,
    output logic             so
);
    logic [WIDTH-1:0] r_po;

    // Next state comes from pi, so the integrator closes the loop externally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_po <= '0;
        end else begin
            r_po <= {pi[WIDTH-2:0], si};
        end
    end

    assign po = r_po;
    assign so = r_po[WIDTH-1];
endmodule

// File: rtl/shift_register_family.sv
// rtl/shift_register_family.sv - the three shift register variants side by side on one serial input
module shift_register_family
    import shift_register_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_si,
    input  logic             i_pi_ovr,
    input  logic [WIDTH-1:0] i_pi,
    output logic [WIDTH-1:0] o_po_d,
    output logic             o_so_d,
    output logic [WIDTH-1:0] o_po_dff,
    output logic             o_so_dff,
    output logic [WIDTH-1:0] o_po_always,
    output logic             o_so_always
);
    sr_word_t w_pi_always;

    // Normally fed back from its own po; i_pi_ovr lets pi be driven directly.
    assign w_pi_always = i_pi_ovr ? i_pi : o_po_always;

    shift_register_d #(.WIDTH(WIDTH)) u_sr_d (
        .clk (i_clk),
        .rst (i_rst),
        .si  (i_si),
        .po  (o_po_d),
        .so  (o_so_d)
    );

    shift_register_dff #(.WIDTH(WIDTH)) u_sr_dff (
        .clk (i_clk),
        .rst (i_rst),
        .si  (i_si),
        .po  (o_po_dff),
        .so  (o_so_dff)
    );

    shift_register_always #(.WIDTH(WIDTH)) u_sr_always (
        .pi  (w_pi_always),
        .clk (i_clk),
        .rst (i_rst),
        .si  (i_si),
        .po  (o_po_always),
        .so  (o_so_always)
    );
endmodule

// File: tb/tb_shift_register_family.sv
// tb/tb_shift_register_family.sv - scoreboard bench comparing all three variants against a model
module tb_shift_register_family;
    logic       clk = 1'b1;
    logic       rst;
    logic       si;
    logic       pi_ovr;
    logic [7:0] pi;
    logic [7:0] po_d;
    logic [7:0] po_dff;
    logic [7:0] po_always;
    logic       so_d;
    logic       so_dff;
    logic       so_always;

    typedef struct packed {
        logic [7:0] chain;
        logic [7:0] alw;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_chain;
    logic [7:0] m_alw;
    logic [7:0] pattern;
    int         vectors = 0;
    int         miscompares = 0;

    shift_register_family dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_si        (si),
        .i_pi_ovr    (pi_ovr),
        .i_pi        (pi),
        .o_po_d      (po_d),
        .o_so_d      (so_d),
        .o_po_dff    (po_dff),
        .o_so_dff    (so_dff),
        .o_po_always (po_always),
        .o_so_always (so_always)
    );

    always #100 clk = ~clk;

    task automatic check_one(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        vectors++;
        assert (sb_q.size() != 0) else begin
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_one({tag, "/po_d"},      po_d,              e.chain);
            check_one({tag, "/po_dff"},    po_dff,            e.chain);
            check_one({tag, "/po_always"}, po_always,         e.alw);
            check_one({tag, "/so_d"},      {7'b0, so_d},      {7'b0, e.chain[7]});
            check_one({tag, "/so_dff"},    {7'b0, so_dff},    {7'b0, e.chain[7]});
            check_one({tag, "/so_always"}, {7'b0, so_always}, {7'b0, e.alw[7]});
        end
    endtask

    task automatic clock_edge(input string tag);
        logic [7:0] prev_a;
        @(posedge clk);
        prev_a  = pi_ovr ? pi : m_alw;
        m_chain = {m_chain[6:0], si};
        m_alw   = {prev_a[6:0], si};
        sb_q.push_back('{chain: m_chain, alw: m_alw});
        @(negedge clk);
        pop_check(tag);
    endtask

    initial begin
        rst     = 1'b1;
        si      = 1'b0;
        pi_ovr  = 1'b0;
        pi      = 8'h00;
        m_chain = 8'h00;
        m_alw   = 8'h00;

        // Reset held across the edge at 200 ns.
        #250;
        sb_q.push_back('{chain: 8'h00, alw: 8'h00});
        pop_check("reset");

        #50;
        si  = 1'b1;
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) clock_edge($sformatf("fill%0d", i));

        si = 1'b0;
        for (int i = 1; i <= 8; i++) clock_edge($sformatf("drain%0d", i));

        fork
            begin
                repeat (8) begin
                    #1379 si = ~si;
                end
            end
        join_none
        for (int i = 1; i <= 57; i++) clock_edge($sformatf("toggle%0d", i));

        pattern = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            si = pattern[i];
            clock_edge($sformatf("a5_bit%0d", i));
        end

        #30;
        rst     = 1'b1;
        m_chain = 8'h00;
        m_alw   = 8'h00;
        #10;
        sb_q.push_back('{chain: 8'h00, alw: 8'h00});
        pop_check("async_rst");
        #20;
        si  = 1'b1;
        rst = 1'b0;
        clock_edge("post_rst");

        pi_ovr = 1'b1;
        pi     = 8'h0F;
        si     = 1'b1;
        clock_edge("pi_ovr");

        pi_ovr = 1'b0;
        clock_edge("pi_fb");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
